sender_cdc: RTL and testbench



---
 rtl/sender_cdc_if.sv | 14 +
 rtl/sender_cdc.sv | 146 ++++++++++++++
 tb/tb_sender_cdc.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sender_cdc_if.sv
// Parallel-in / serial-out bus between the producer side and sender_cdc.
// The master drives the word and its send request; the slave (serializer)
// returns the serial line and its busy flag.
interface sender_cdc_if #(
  parameter int unsigned WIDTH = 40
);
  logic [WIDTH-1:0] data;
  logic             in_valid;
  logic             sout;
  logic             busy;

  modport master (output data, output in_valid, input sout, input busy);
  modport slave  (input data, input in_valid, output sout, output busy);
endinterface

// File: rtl/sender_cdc.sv
// sender_cdc: serializer for the nextasic path.
// Takes a quasi-static WIDTH-bit word plus an asynchronous send request,
// synchronizes and edge-detects the request, then shifts the word out
// MSB first, one bit per out_clk. Requests arriving while a frame is in
// flight are dropped; a request landing on the frame's final edge is
// accepted with no gap cycle.
// Optional feature: define SENDER_PARITY_EN to append an even-parity bit
// (XOR of all data bits) after the LSB, making frames WIDTH+1 bits long.
module sender_cdc #(
  parameter int unsigned WIDTH       = 40,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          IDLE_LEVEL  = 1'b1
) (
  input  logic        out_clk,
  input  logic        reset,
  sender_cdc_if.slave bus
);

`ifdef SENDER_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned    CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
`ifdef SENDER_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_CNT  = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   v_s;
  logic                   v_s_d_q;
  logic                   start;
  logic                   load;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sout_q, sout_d;
  logic                   busy_q, busy_d;
`ifdef SENDER_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Request synchronizer and rising-edge detector.
  always_ff @(posedge out_clk) begin
    if (reset) begin
      sync_q  <= '0;
      v_s_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.in_valid};
      v_s_d_q <= v_s;
    end
  end

  assign v_s   = sync_q[SYNC_STAGES-1];
  assign start = v_s & ~v_s_d_q;

  // State, shifter and registered output flops.
  always_ff @(posedge out_clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef SENDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
`ifdef SENDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: idle/accept, shift one bit per clock, end-of-frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    load    = 1'b0;
`ifdef SENDER_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        sout_d = IDLE_LEVEL;
        busy_d = 1'b0;
        load   = start;
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          // Last bit has been on the line for a full clock.
          state_d = IDLE;
          sout_d  = IDLE_LEVEL;
          busy_d  = 1'b0;
          load    = start;
        end else begin
`ifdef SENDER_PARITY_EN
          if (cnt_q == PAR_CNT) begin
            sout_d = par_q;
          end else begin
            sout_d = shreg_q[WIDTH-1];
          end
`else
          sout_d  = shreg_q[WIDTH-1];
`endif
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // MSB goes straight to the line; the rest waits in the shifter.
    if (load) begin
      state_d = SHIFT;
      shreg_d = {bus.data[WIDTH-2:0], 1'b0};
      sout_d  = bus.data[WIDTH-1];
      cnt_d   = '0;
      busy_d  = 1'b1;
`ifdef SENDER_PARITY_EN
      par_d   = ^bus.data;
`endif
    end
  end

  assign bus.sout = sout_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sender_cdc.sv
// Bench for sender_cdc: queue-based reference model checked every cycle,
// plus directed frames with literal bit-stream / length expectations.
module tb_sender_cdc;

  localparam int unsigned WIDTH = 40;
  localparam int unsigned SYNC  = 2;
  localparam bit          IDLE  = 1'b1;
`ifdef SENDER_PARITY_EN
  localparam int unsigned FLEN  = WIDTH + 1;
`else
  localparam int unsigned FLEN  = WIDTH;
`endif

  logic out_clk = 1'b0;
  logic reset;

  sender_cdc_if #(.WIDTH(WIDTH)) bus ();

  sender_cdc #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC),
    .IDLE_LEVEL (IDLE)
  ) dut (
    .out_clk(out_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 out_clk = ~out_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: request history, and the bits still owed on the line.
  bit hv [0:SYNC];
  bit fq [$];
  bit exp_sout = IDLE;
  bit exp_busy = 1'b0;
  int model_frames = 0;

  always @(posedge out_clk) begin
    bit start;
    logic [WIDTH-1:0] dv;
    if (reset) begin
      for (int i = 0; i <= SYNC; i++) hv[i] = 1'b0;
      fq.delete();
      exp_sout = IDLE;
      exp_busy = 1'b0;
    end else begin
      start = hv[SYNC-1] && !hv[SYNC];
      for (int i = SYNC; i > 0; i--) hv[i] = hv[i-1];
      hv[0] = bus.in_valid;
      if (fq.size() == 0 && start) begin
        dv = bus.data;
        for (int i = WIDTH - 1; i >= 0; i--) fq.push_back(dv[i]);
`ifdef SENDER_PARITY_EN
        fq.push_back(^dv);
`endif
        model_frames++;
      end
      if (fq.size() > 0) begin
        exp_sout = fq.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_sout = IDLE;
        exp_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare plus capture of what the DUT actually sent.
  logic [63:0] cap = '0;
  int  bcnt = 0;
  int  dut_frames = 0;
  bit  prev_busy = 1'b0;

  always @(negedge out_clk) begin
    if (chk_en) begin
      total++;
      if (bus.sout !== exp_sout) begin
        bad++;
        $display("FAIL sout t=%0t got %b want %b", $time, bus.sout, exp_sout);
      end
      total++;
      if (bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL busy t=%0t got %b want %b", $time, bus.busy, exp_busy);
      end
      if (bus.busy === 1'b1) begin
        cap = {cap[62:0], bus.sout};
        bcnt++;
        if (!prev_busy) dut_frames++;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge out_clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] last_frame();
    logic [63:0] mask;
    mask = (64'd1 << FLEN) - 64'd1;
    return cap & mask;
  endfunction

  function automatic logic [63:0] stream_of(input logic [WIDTH-1:0] d);
`ifdef SENDER_PARITY_EN
    return 64'({d, ^d});
`else
    return 64'(d);
`endif
  endfunction

  int f0, b0, m0, hold, gap;
  logic [WIDTH-1:0] dA, dB;

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.data     = '0;
    @(posedge out_clk);
    #1 chk_en = 1'b1;
    tick(3);
    check("rst_sout", 64'(bus.sout), 64'(1));
    check("rst_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    tick(50);
    check("idle_frames", 64'(dut_frames), 64'(0));
    check("idle_bits", 64'(bcnt), 64'(0));

    // Single frame, long hold.
    f0 = dut_frames; b0 = bcnt; m0 = model_frames;
    bus.data = 40'hD999999991;
    bus.in_valid = 1'b1;
    tick(2);
    check("lat_E1_busy", 64'(bus.busy), 64'(0));
    tick(1);
    check("lat_E2_busy", 64'(bus.busy), 64'(1));
    check("lat_E2_msb", 64'(bus.sout), 64'(1));
    tick(197);
    bus.in_valid = 1'b0;
    tick(10);
    check("f1_stream", last_frame(), stream_of(40'hD999999991));
    check("f1_len", 64'(bcnt - b0), 64'(FLEN));
    check("f1_frames", 64'(dut_frames - f0), 64'(1));
    check("f1_model", 64'(model_frames - m0), 64'(1));
`ifdef SENDER_PARITY_EN
    check("f1_parity", 64'(cap[0]), 64'(0));
`endif

    // Second frame after gap.
    f0 = dut_frames; b0 = bcnt;
    bus.data = 40'h9999999993;
    bus.in_valid = 1'b1;
    tick(200);
    bus.in_valid = 1'b0;
    tick(10);
    check("f2_stream", last_frame(), stream_of(40'h9999999993));
    check("f2_len", 64'(bcnt - b0), 64'(FLEN));
    check("f2_idle_sout", 64'(bus.sout), 64'(1));

`ifdef SENDER_PARITY_EN
    b0 = bcnt;
    bus.data = 40'hD999999990;
    bus.in_valid = 1'b1;
    tick(100);
    bus.in_valid = 1'b0;
    tick(10);
    check("par1_bit", 64'(cap[0]), 64'(1));
    check("par1_len", 64'(bcnt - b0), 64'(41));
`endif

    // Request during busy is dropped.
    f0 = dut_frames; m0 = model_frames;
    bus.data = 40'h0123456789;
    bus.in_valid = 1'b1;
    tick(10);
    bus.in_valid = 1'b0;
    tick(10);
    bus.in_valid = 1'b1;
    tick(60);
    bus.in_valid = 1'b0;
    tick(20);
    check("drop_frames", 64'(dut_frames - f0), 64'(1));
    check("drop_model", 64'(model_frames - m0), 64'(1));

    // Reset on the 15th bit aborts the frame.
    f0 = dut_frames; b0 = bcnt;
    bus.data = 40'hFFFFFFFFFF;
    bus.in_valid = 1'b1;
    tick(16);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    tick(1);
    check("abort_sout", 64'(bus.sout), 64'(1));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_bits", 64'(bcnt - b0), 64'(14));
    reset = 1'b0;
    tick(50);
    check("abort_quiet", 64'(bcnt - b0), 64'(14));

    // Request already high across reset release yields one frame.
    f0 = dut_frames; b0 = bcnt;
    bus.data = 40'h5A5A5A5A5A;
    bus.in_valid = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(FLEN + 30);
    bus.in_valid = 1'b0;
    tick(5);
    check("rstrel_frames", 64'(dut_frames - f0), 64'(1));
    check("rstrel_stream", last_frame(), stream_of(40'h5A5A5A5A5A));

    // Start landing on the final edge: back-to-back, no gap.
    f0 = dut_frames; b0 = bcnt; m0 = model_frames;
    dA = 40'hC3C3C3C3C3;
    dB = 40'h1E1E1E1E1E;
    bus.data = dA;
    bus.in_valid = 1'b1;
    tick(5);
    bus.in_valid = 1'b0;
    tick(FLEN - 5);
    bus.data = dB;
    bus.in_valid = 1'b1;
    tick(2 * FLEN + 10);
    bus.in_valid = 1'b0;
    tick(5);
    check("b2b_busy_rises", 64'(dut_frames - f0), 64'(1));
    check("b2b_model", 64'(model_frames - m0), 64'(2));
    check("b2b_len", 64'(bcnt - b0), 64'(2 * FLEN));
    check("b2b_stream", last_frame(), stream_of(dB));

    // Randomized requests, holds, gaps and mid-frame data changes.
    for (int n = 0; n < 30; n++) begin
      bus.data = WIDTH'({$urandom(), $urandom()});
      bus.in_valid = 1'b1;
      hold = int'($urandom_range(3, 80));
      tick(3);
      bus.data = WIDTH'({$urandom(), $urandom()});
      tick(hold - 3);
      bus.in_valid = 1'b0;
      gap = int'($urandom_range(1, 60));
      tick(gap);
    end
    tick(FLEN + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
